// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - image geometry, host state encoding and address helpers for the LBP image host
package lbp_pkg;
   localparam int IMG_W     = 128;
   localparam int IMG_H     = 128;
   localparam int NPIX      = IMG_W * IMG_H;
   localparam int INNER_PIX = (IMG_W - 2) * (IMG_H - 2);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SERVE = 2'd1,
      ST_DUMP  = 2'd2,
      ST_DONE  = 2'd3
   } host_state_t;

   function automatic logic addr_ok(input int unsigned addr, input int unsigned npix = NPIX);
      return addr < npix;
   endfunction

   function automatic logic is_border(input int unsigned addr,
                                      input int unsigned w = IMG_W,
                                      input int unsigned h = IMG_H);
      int unsigned row;
      int unsigned col;
      row = addr / w;
      col = addr % w;
      return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
   endfunction
endpackage

// File: rtl/lbp_host_sram.sv
// rtl/lbp_host_sram.sv - single-port synchronous RAM, one-cycle read, write-first
module lbp_host_sram #(
   parameter int AW = 14,
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_en,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rdata;

   // Read data only moves on an enabled access, so it holds while idle.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            r_rdata       <= i_wdata;
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/lbp_image_host.sv
// rtl/lbp_image_host.sv - gray-image server and lbp result collector/streamer for the LBP engine
// Optional write checker (border, duplicate, count) is enabled with LBP_HOST_CHECK_EN.
module lbp_image_host
   import lbp_pkg::*;
#(
   parameter int IMG_W  = lbp_pkg::IMG_W,
   parameter int IMG_H  = lbp_pkg::IMG_H,
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ld_valid,
   input  logic [DATA_W-1:0] i_ld_data,
   output logic              o_ld_ready,
   input  logic [ADDR_W-1:0] i_gray_addr,
   input  logic              i_gray_req,
   output logic              o_gray_ready,
   output logic [DATA_W-1:0] o_gray_data,
   input  logic [ADDR_W-1:0] i_lbp_addr,
   input  logic              i_lbp_valid,
   input  logic [DATA_W-1:0] i_lbp_data,
   input  logic              i_finish,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_rd_ready,
   output logic              o_done,
   output logic              o_err
);
   localparam int unsigned L_NPIX  = IMG_W * IMG_H;
   localparam int unsigned L_INNER = (IMG_W - 2) * (IMG_H - 2);
   localparam int          CW      = ADDR_W + 1;

   host_state_t r_state;
   logic [CW-1:0] r_cnt;
   logic r_ld_ready, r_gray_ready, r_gray_zero, r_rd_valid, r_done, r_err;

   logic              w_ld_fire, w_last_ld, w_rd_ok, w_wr_ok, w_lbp_wr;
   logic              w_rd_fire, w_dump_more, w_base_err, w_chk_err;
   logic [ADDR_W-1:0] w_cnt_addr;
   logic              w_gray_en;
   logic [ADDR_W-1:0] w_gray_addr;
   logic [DATA_W-1:0] w_gray_rdata;
   logic              w_lbp_en, w_lbp_we;
   logic [ADDR_W-1:0] w_lbp_addr;
   logic [DATA_W-1:0] w_lbp_wdata, w_lbp_rdata;

   assign w_cnt_addr  = r_cnt[ADDR_W-1:0];
   assign w_ld_fire   = i_ld_valid && r_ld_ready;
   assign w_last_ld   = (r_cnt == CW'(L_NPIX - 1));
   assign w_rd_ok     = addr_ok(32'(i_gray_addr), L_NPIX);
   assign w_wr_ok     = addr_ok(32'(i_lbp_addr), L_NPIX);
   assign w_lbp_wr    = (r_state == ST_SERVE) && i_lbp_valid && w_wr_ok;
   assign w_rd_fire   = r_rd_valid && i_rd_ready;
   assign w_dump_more = (r_cnt != CW'(L_NPIX));

   assign w_base_err = ((r_state == ST_LOAD) && i_gray_req) ||
                       ((r_state != ST_SERVE) && i_lbp_valid) ||
                       ((r_state == ST_SERVE) && i_gray_req && !w_rd_ok) ||
                       ((r_state == ST_SERVE) && i_lbp_valid && !w_wr_ok);

   assign w_gray_en   = w_ld_fire || ((r_state == ST_SERVE) && i_gray_req);
   assign w_gray_addr = w_ld_fire ? w_cnt_addr : i_gray_addr;

   // The result buffer port is shared in time: clear in LOAD, engine writes in SERVE, stream reads in DUMP.
   always_comb begin
      w_lbp_en    = 1'b0;
      w_lbp_we    = 1'b0;
      w_lbp_addr  = w_cnt_addr;
      w_lbp_wdata = '0;
      case (r_state)
         ST_LOAD: begin
            w_lbp_en = w_ld_fire;
            w_lbp_we = 1'b1;
         end
         ST_SERVE: begin
            w_lbp_en    = w_lbp_wr;
            w_lbp_we    = 1'b1;
            w_lbp_addr  = i_lbp_addr;
            w_lbp_wdata = i_lbp_data;
         end
         ST_DUMP: w_lbp_en = !r_rd_valid || (w_rd_fire && w_dump_more);
         default: ;
      endcase
   end

   lbp_host_sram #(.AW(ADDR_W), .DW(DATA_W)) u_gray_mem (
      .i_clk   (i_clk),
      .i_en    (w_gray_en),
      .i_we    (w_ld_fire),
      .i_addr  (w_gray_addr),
      .i_wdata (i_ld_data),
      .o_rdata (w_gray_rdata)
   );

   lbp_host_sram #(.AW(ADDR_W), .DW(DATA_W)) u_lbp_mem (
      .i_clk   (i_clk),
      .i_en    (w_lbp_en),
      .i_we    (w_lbp_we),
      .i_addr  (w_lbp_addr),
      .i_wdata (w_lbp_wdata),
      .o_rdata (w_lbp_rdata)
   );

`ifdef LBP_HOST_CHECK_EN
   logic [CW-1:0] r_wr_cnt;
   logic          r_written [0:(1<<ADDR_W)-1];

   always_ff @(posedge i_clk) begin
      if (w_ld_fire)
         r_written[w_cnt_addr] <= 1'b0;
      if (w_lbp_wr)
         r_written[i_lbp_addr] <= 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || (r_state == ST_LOAD))
         r_wr_cnt <= '0;
      else if (w_lbp_wr)
         r_wr_cnt <= r_wr_cnt + 1'b1;
   end

   // The count at finish includes a write landing in the same cycle.
   assign w_chk_err = (w_lbp_wr && (is_border(32'(i_lbp_addr), IMG_W, IMG_H) || r_written[i_lbp_addr])) ||
                      ((r_state == ST_SERVE) && i_finish &&
                       ((r_wr_cnt + CW'(w_lbp_wr)) != CW'(L_INNER)));
`else
   assign w_chk_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_LOAD;
         r_cnt        <= '0;
         r_ld_ready   <= 1'b0;
         r_gray_ready <= 1'b0;
         r_gray_zero  <= 1'b1;
         r_rd_valid   <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         if (w_base_err || w_chk_err)
            r_err <= 1'b1;
         case (r_state)
            ST_LOAD: begin
               r_ld_ready <= 1'b1;
               if (w_ld_fire) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last_ld) begin
                     r_ld_ready   <= 1'b0;
                     r_gray_ready <= 1'b1;
                     r_state      <= ST_SERVE;
                  end
               end
            end
            ST_SERVE: begin
               if (i_gray_req)
                  r_gray_zero <= !w_rd_ok;
               if (i_finish) begin
                  r_gray_ready <= 1'b0;
                  r_cnt        <= '0;
                  r_state      <= ST_DUMP;
               end
            end
            ST_DUMP: begin
               if (!r_rd_valid) begin
                  r_rd_valid <= 1'b1;
                  r_cnt      <= r_cnt + 1'b1;
               end else if (w_rd_fire) begin
                  if (w_dump_more) begin
                     r_cnt <= r_cnt + 1'b1;
                  end else begin
                     r_rd_valid <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ld_ready   = r_ld_ready;
   assign o_gray_ready = r_gray_ready;
   assign o_gray_data  = r_gray_zero ? '0 : w_gray_rdata;
   assign o_rd_valid   = r_rd_valid;
   assign o_rd_data    = r_rd_valid ? w_lbp_rdata : '0;
   assign o_done       = r_done;
   assign o_err        = r_err;
endmodule

// File: tb/tb_lbp_image_host.sv
// tb/tb_lbp_image_host.sv - randomized self-checking bench for lbp_image_host against an array reference model
module tb_lbp_image_host;
   localparam int W     = 128;
   localparam int H     = 128;
   localparam int NPIX  = W * H;
   localparam int INNER = (W - 2) * (H - 2);
   localparam int AW    = 15;
   localparam int DW    = 8;
`ifdef LBP_HOST_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, ld_valid, gray_req, lbp_valid, finish, rd_ready;
   logic [DW-1:0] ld_data, lbp_data;
   logic [AW-1:0] gray_addr, lbp_addr;
   logic          ld_ready, gray_ready, rd_valid, done, err;
   logic [DW-1:0] gray_data, rd_data;

   int checks   = 0;
   int failures = 0;

   logic [7:0] gray_m [NPIX];
   logic [7:0] lbp_m  [NPIX];
   bit         written_m [NPIX];
   int         wr_count;
   bit         err_m;
   logic [7:0] gd_m;

   always #5 clk = ~clk;

   lbp_image_host #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
      .i_gray_addr(gray_addr), .i_gray_req(gray_req), .o_gray_ready(gray_ready), .o_gray_data(gray_data),
      .i_lbp_addr(lbp_addr), .i_lbp_valid(lbp_valid), .i_lbp_data(lbp_data), .i_finish(finish),
      .o_rd_valid(rd_valid), .o_rd_data(rd_data), .i_rd_ready(rd_ready),
      .o_done(done), .o_err(err)
   );

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      ld_valid = 0; ld_data = 0; gray_req = 0; gray_addr = 0;
      lbp_valid = 0; lbp_addr = 0; lbp_data = 0; finish = 0; rd_ready = 0;
   endtask

   function automatic bit on_border(int a);
      return (a / W == 0) || (a / W == H - 1) || (a % W == 0) || (a % W == W - 1);
   endfunction

   task automatic model_write(int a, logic [7:0] d);
      if (a >= NPIX) begin
         err_m = 1;
      end else begin
         if (CHK && (on_border(a) || written_m[a])) err_m = 1;
         written_m[a] = 1;
         wr_count++;
         lbp_m[a] = d;
      end
   endtask

   task automatic model_finish;
      if (CHK && wr_count != INNER) err_m = 1;
   endtask

   task automatic apply_reset;
      idle();
      reset = 1;
      tick();
      reset = 0;
      err_m = 0; wr_count = 0; gd_m = 0;
   endtask

   task automatic test_reset;
      apply_reset();
      checks++;
      if ({ld_ready, gray_ready, rd_valid, done, err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000", {ld_ready, gray_ready, rd_valid, done, err});
      end
      checks++;
      if ({gray_data, rd_data} !== 16'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0000", {gray_data, rd_data});
      end
   endtask

   task automatic test_load(input bit ramp, input bit gaps);
      int  k   = 0;
      int  cyc = 0;
      int  bad = 0;
      logic fire;
      tick();
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL load_ready_up got=%b exp=1", ld_ready);
      end
      while (k < NPIX && cyc < 4 * NPIX) begin
         ld_valid = gaps ? ($urandom_range(0, 7) != 0) : 1'b1;
         ld_data  = ramp ? k[7:0] : 8'($urandom);
         fire     = ld_valid && ld_ready;
         if (ld_ready !== 1'b1 || gray_ready !== 1'b0 || gray_data !== 8'h00) bad++;
         tick();
         if (fire) begin
            gray_m[k] = ld_data; lbp_m[k] = 0; written_m[k] = 0;
            k++;
         end
         cyc++;
      end
      idle();
      checks++;
      if (k != NPIX) begin
         failures++;
         $display("FAIL load_count got=%0d exp=%0d", k, NPIX);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL load_outputs bad_cycles=%0d exp=0", bad);
      end
      checks++;
      if (ld_ready !== 1'b0 || gray_ready !== 1'b1) begin
         failures++;
         $display("FAIL load_to_serve ld_ready=%b gray_ready=%b exp=0/1", ld_ready, gray_ready);
      end
      checks++;
      if (err !== err_m) begin
         failures++;
         $display("FAIL load_err got=%b exp=%b", err, err_m);
      end
   endtask

   task automatic test_gray_reads;
      int         addrs [3] = '{0, 129, 16383};
      logic [7:0] exps  [3] = '{8'h00, 8'h81, 8'hFF};
      int bad = 0;
      int a;
      gray_req = 1;
      ld_valid = 1;
      for (int i = 0; i < 3; i++) begin
         gray_addr = AW'(addrs[i]);
         tick();
         gd_m = exps[i];
         checks++;
         if (gray_data !== exps[i]) begin
            failures++;
            $display("FAIL gray_read_%0d got=%h exp=%h", addrs[i], gray_data, exps[i]);
         end
      end
      checks++;
      if (ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL ld_ignored_in_serve ld_ready=%b exp=0", ld_ready);
      end
      idle();
      gray_addr = 5;
      tick();
      checks++;
      if (gray_data !== 8'hFF) begin
         failures++;
         $display("FAIL gray_hold got=%h exp=ff", gray_data);
      end
      for (int i = 0; i < 300; i++) begin
         gray_req  = 1'($urandom_range(0, 1));
         a         = $urandom_range(0, NPIX - 1);
         gray_addr = AW'(a);
         tick();
         if (gray_req) gd_m = gray_m[a];
         if (gray_data !== gd_m) bad++;
      end
      idle();
      checks++;
      if (bad != 0 || err !== err_m) begin
         failures++;
         $display("FAIL gray_random bad=%0d err=%b exp_err=%b", bad, err, err_m);
      end
   endtask

   task automatic test_border_write;
      lbp_valid = 1; lbp_addr = AW'(NPIX - 1); lbp_data = 8'h3C;
      tick();
      idle();
      model_write(NPIX - 1, 8'h3C);
      checks++;
      if (err !== err_m) begin
         failures++;
         $display("FAIL border_write_err got=%b exp=%b", err, err_m);
      end
   endtask

   task automatic test_out_of_range;
      gray_req = 1; gray_addr = AW'(NPIX + $urandom_range(0, NPIX - 1));
      tick();
      idle();
      err_m = 1; gd_m = 0;
      checks++;
      if (err !== 1'b1 || gray_data !== 8'h00) begin
         failures++;
         $display("FAIL oor_read err=%b data=%h exp=1/00", err, gray_data);
      end
      lbp_valid = 1; lbp_addr = AW'(NPIX); lbp_data = 8'h77;
      tick();
      idle();
      model_write(NPIX, 8'h77);
      checks++;
      if (err !== err_m) begin
         failures++;
         $display("FAIL oor_write_err got=%b exp=%b", err, err_m);
      end
   endtask

   task automatic run_dump(input int max_words, output logic [7:0] w0, output logic [7:0] w128,
                           output logic [7:0] w129, output logic [7:0] wlast, output int got);
      int idx = 0, cyc = 0, bad = 0, unstable = 0, early = 0, pat = 0;
      logic hs, stall;
      logic [7:0] held;
      w0 = 'x; w128 = 'x; w129 = 'x; wlast = 'x;
      while (idx < max_words && cyc < 4 * NPIX) begin
         if (rd_valid && pat < 4) begin
            rd_ready = (pat == 0 || pat == 3);
            pat++;
         end else begin
            rd_ready = ($urandom_range(0, 7) != 0);
         end
         hs    = rd_valid && rd_ready;
         stall = rd_valid && !rd_ready;
         held  = rd_data;
         if (done !== 1'b0) early++;
         if (hs) begin
            if (rd_data !== lbp_m[idx]) bad++;
            case (idx)
               0:        w0    = rd_data;
               128:      w128  = rd_data;
               129:      w129  = rd_data;
               NPIX - 1: wlast = rd_data;
               default: ;
            endcase
            idx++;
         end
         tick();
         cyc++;
         if (stall && (rd_valid !== 1'b1 || rd_data !== held)) unstable++;
      end
      rd_ready = 0;
      got = idx;
      checks++;
      if (idx != max_words || bad != 0) begin
         failures++;
         $display("FAIL dump_words got=%0d exp=%0d data_mismatches=%0d", idx, max_words, bad);
      end
      checks++;
      if (unstable != 0 || early != 0) begin
         failures++;
         $display("FAIL dump_backpressure unstable=%0d early_done=%0d exp=0/0", unstable, early);
      end
   endtask

   task automatic test_finish_and_partial_dump;
      logic [7:0] w0, w128, w129, wlast;
      int got;
      lbp_valid = 1; lbp_addr = AW'(129); lbp_data = 8'hA5; finish = 1;
      tick();
      idle();
      model_write(129, 8'hA5);
      model_finish();
      checks++;
      if (gray_ready !== 1'b0 || err !== err_m) begin
         failures++;
         $display("FAIL finish_state gray_ready=%b err=%b exp=0/%b", gray_ready, err, err_m);
      end
      run_dump(300, w0, w128, w129, wlast, got);
      checks++;
      if (w129 !== 8'hA5 || w0 !== 8'h00 || w128 !== 8'h00) begin
         failures++;
         $display("FAIL dump_words_0_128_129 got=%h/%h/%h exp=00/00/a5", w0, w128, w129);
      end
   endtask

   task automatic test_reset_mid_dump;
      checks++;
      if (rd_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_dump_active rd_valid=%b exp=1", rd_valid);
      end
      apply_reset();
      checks++;
      if (rd_valid !== 1'b0 || done !== 1'b0 || rd_data !== 8'h00) begin
         failures++;
         $display("FAIL mid_dump_reset rd_valid=%b done=%b rd_data=%h exp=0/0/00", rd_valid, done, rd_data);
      end
      tick();
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_dump_reload_ready got=%b exp=1", ld_ready);
      end
   endtask

   task automatic test_engine_run;
      int bad = 0, n = 0, a, ga;
      logic [7:0] d;
      for (int r = 1; r < H - 1; r++) begin
         for (int c = 1; c < W - 1; c++) begin
            a  = r * W + c;
            d  = 8'($urandom);
            ga = $urandom_range(0, NPIX - 1);
            lbp_valid = 1; lbp_addr = AW'(a); lbp_data = d;
            gray_req  = 1'($urandom_range(0, 1)); gray_addr = AW'(ga);
            n++;
            finish = (n == INNER);
            tick();
            model_write(a, d);
            if (gray_req) gd_m = gray_m[ga];
            if (gray_data !== gd_m) bad++;
         end
      end
      idle();
      model_finish();
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL engine_gray_reads mismatches=%0d exp=0", bad);
      end
      checks++;
      if (err !== err_m || err !== 1'b0) begin
         failures++;
         $display("FAIL engine_run_err got=%b exp=0", err);
      end
   endtask

   task automatic test_full_dump;
      logic [7:0] w0, w128, w129, wlast;
      int got;
      run_dump(NPIX, w0, w128, w129, wlast, got);
      checks++;
      if (done !== 1'b1 || rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL dump_end done=%b rd_valid=%b exp=1/0", done, rd_valid);
      end
      checks++;
      if (wlast !== 8'h00 || w0 !== 8'h00) begin
         failures++;
         $display("FAIL reload_cleared word0=%h word_last=%h exp=00/00", w0, wlast);
      end
      lbp_valid = 1; lbp_addr = AW'(200);
      tick();
      idle();
      checks++;
      if (err !== 1'b1 || done !== 1'b1) begin
         failures++;
         $display("FAIL write_after_done err=%b done=%b exp=1/1", err, done);
      end
   endtask

   task automatic test_load_errors;
      apply_reset();
      tick();
      ld_valid = 1;
      for (int i = 0; i < 5; i++) begin
         ld_data = 8'($urandom);
         tick();
      end
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("FAIL load_clean_err got=%b exp=0", err);
      end
      ld_valid = 0; gray_req = 1; gray_addr = 3;
      tick();
      idle();
      checks++;
      if (err !== 1'b1 || gray_data !== 8'h00 || gray_ready !== 1'b0) begin
         failures++;
         $display("FAIL gray_req_in_load err=%b data=%h gray_ready=%b exp=1/00/0", err, gray_data, gray_ready);
      end
      apply_reset();
      tick();
      lbp_valid = 1; lbp_addr = 7;
      tick();
      idle();
      tick();
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL lbp_valid_in_load err=%b exp=1", err);
      end
   endtask

   initial begin
      idle();
      reset = 0;
      test_reset();
      test_load(1'b1, 1'b1);
      test_gray_reads();
      test_border_write();
      test_out_of_range();
      test_finish_and_partial_dump();
      test_reset_mid_dump();
      test_load(1'b0, 1'b0);
      test_engine_run();
      test_full_dump();
      test_load_errors();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
